sram_phase_sequencer: RTL

Top-level sequencer and SRAM arbiter for the image-processing pipeline. It owns the single-port external SRAM controller's request port and grants it, by phase, to the UART loader, the M1 upsampling/colour-conversion unit, or the VGA reader. It also sequences the phases: image load over UART, then M1 processing, then display.

---
 rtl/sram_phase_sequencer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sram_phase_sequencer.sv
// rtl/sram_phase_sequencer.sv - phase sequencer and SRAM request-port arbiter (UART load, M1, VGA)
module sram_phase_sequencer #(
  parameter logic [25:0] TIMEOUT = 26'd49999999
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [3:0]  PB_pushed,
  input  logic [17:0] UART_SRAM_address,
  input  logic [15:0] UART_SRAM_write_data,
  input  logic        UART_SRAM_we_n,
  output logic        UART_rx_initialize,
  output logic        UART_rx_enable,
  input  logic [17:0] M1_address,
  input  logic [15:0] M1_write_data,
  input  logic        M1_wr_n,
  output logic        M1_start,
  input  logic        M1_finish,
  input  logic [17:0] VGA_SRAM_address,
  output logic        VGA_enable,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic [2:0]  Phase_state
);

  typedef enum logic [2:0] {
    S_IDLE           = 3'd0,
    S_ENABLE_UART_RX = 3'd1,
    S_WAIT_UART_RX   = 3'd2,
    S_M1_START       = 3'd3,
    S_M1_WAIT        = 3'd4
  } state_e;

  state_e      state_q;
  logic [25:0] timer_q;
  logic        seen_write_q;
  logic        vga_enable_q;
  logic        uart_init_q;
  logic        uart_enable_q;
  logic        m1_start_q;

  // Only buttons 0 and 1 have a meaning here.
  logic unused_pb;
  assign unused_pb = ^PB_pushed[3:2];

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q       <= S_IDLE;
      timer_q       <= 26'd0;
      seen_write_q  <= 1'b0;
      vga_enable_q  <= 1'b1;
      uart_init_q   <= 1'b0;
      uart_enable_q <= 1'b0;
      m1_start_q    <= 1'b0;
    end else begin
      uart_init_q <= 1'b0;
      m1_start_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (PB_pushed[0]) begin
            state_q       <= S_ENABLE_UART_RX;
            uart_init_q   <= 1'b1;
            uart_enable_q <= 1'b1;
            vga_enable_q  <= 1'b0;
            timer_q       <= 26'd0;
            seen_write_q  <= 1'b0;
          end else if (PB_pushed[1]) begin
            state_q      <= S_M1_START;
            m1_start_q   <= 1'b1;
            vga_enable_q <= 1'b0;
          end
        end
        S_ENABLE_UART_RX: begin
          state_q <= S_WAIT_UART_RX;
        end
        S_WAIT_UART_RX: begin
          // A write always restarts the idle window, even on the terminal count.
          if (!UART_SRAM_we_n) begin
            timer_q      <= 26'd0;
            seen_write_q <= 1'b1;
          end else if (timer_q == TIMEOUT) begin
            uart_enable_q <= 1'b0;
            m1_start_q    <= 1'b1;
            state_q       <= S_M1_START;
          end else if (seen_write_q) begin
            timer_q <= timer_q + 26'd1;
          end
        end
        S_M1_START: begin
          state_q <= S_M1_WAIT;
        end
        S_M1_WAIT: begin
          if (M1_finish) begin
            vga_enable_q <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          state_q       <= S_IDLE;
          timer_q       <= 26'd0;
          seen_write_q  <= 1'b0;
          vga_enable_q  <= 1'b1;
          uart_enable_q <= 1'b0;
        end
      endcase
    end
  end

  // Grant follows the registered state only, so ownership switches on clock edges.
  always_comb begin
    SRAM_address    = VGA_SRAM_address;
    SRAM_write_data = 16'd0;
    SRAM_we_n       = 1'b1;
    case (state_q)
      S_ENABLE_UART_RX, S_WAIT_UART_RX: begin
        SRAM_address    = UART_SRAM_address;
        SRAM_write_data = UART_SRAM_write_data;
        SRAM_we_n       = UART_SRAM_we_n;
      end
      S_M1_START, S_M1_WAIT: begin
        SRAM_address    = M1_address;
        SRAM_write_data = M1_write_data;
        SRAM_we_n       = M1_wr_n;
      end
      default: begin
        SRAM_address    = VGA_SRAM_address;
        SRAM_write_data = 16'd0;
        SRAM_we_n       = 1'b1;
      end
    endcase
  end

  assign UART_rx_initialize = uart_init_q;
  assign UART_rx_enable     = uart_enable_q;
  assign M1_start           = m1_start_q;
  assign VGA_enable         = vga_enable_q;
  assign Phase_state        = state_q;

endmodule
